// File: rtl/reg_arb_pkg.sv
// Shared constants and types for the round-robin register arbiter.
// The state enum is exported for bench and formal visibility.
package reg_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin priority scan starting at ptr.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_grant
    import reg_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gid,
    output logic            any
);

    always_comb begin
        int idx;
        grant = '0;
        gid   = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (en && !any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                gid        = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter feeding one holding register with val/rdy on
// both sides; drain and fill may happen in the same cycle.
module reg_rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_val,
    output logic [NREQ-1:0]        req_rdy,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(NREQ)-1:0] out_id
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gid;
    logic [NREQ-1:0]  grant;
    logic             accept;
    logic             space;
    logic             en;
    logic [WIDTH-1:0] sel_data;

    assign space    = !out_val || out_rdy;
    assign en       = space && !reset;
    assign req_rdy  = grant;
    assign sel_data = req_data[gid*WIDTH +: WIDTH];

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_grant (
        .req   (req_val),
        .ptr   (ptr),
        .en    (en),
        .grant (grant),
        .gid   (gid),
        .any   (accept)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_val  <= 1'b0;
            out_data <= '0;
            out_id   <= '0;
            ptr      <= '0;
        end else if (accept) begin
            out_val  <= 1'b1;
            out_data <= sel_data;
            out_id   <= gid;
            ptr      <= (gid == IDW'(NREQ-1)) ? '0 : gid + IDW'(1);
        end else if (out_rdy) begin
            out_val  <= 1'b0;
        end
    end

`ifdef FORMAL
    logic f_past_valid = 1'b0;
    always_ff @(posedge clk) f_past_valid <= 1'b1;

    a_onehot: assert property (@(posedge clk)
        disable iff (!f_past_valid) $onehot0(req_rdy));

    a_hold: assert property (@(posedge clk)
        disable iff (!f_past_valid || reset)
        out_val && !out_rdy |=> $stable(out_data) && $stable(out_id));

    a_load: assert property (@(posedge clk)
        disable iff (!f_past_valid || reset)
        accept |=> out_data == $past(sel_data));
`endif

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Directed vector bench for reg_rr_arbiter (NREQ=4, WIDTH=8).
// Table rows plus hand sequences for throughput and stall release.
module tb_reg_rr_arbiter;

    import reg_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_val;
    logic [3:0]  req_rdy;
    logic [31:0] req_data;
    logic        out_val;
    logic        out_rdy;
    logic [7:0]  out_data;
    logic [1:0]  out_id;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  val;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  rr;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  oid;
    } vec_t;

    localparam logic [31:0] D = 32'h1312_1110;

    vec_t tv[28];

    reg_rr_arbiter #(.NREQ(4), .WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_data (req_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_id   (out_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        buf_state_t st;
        int waited;
        bit got;

        // rst val data ordy | req_rdy out_val out_data out_id
        tv[0]  = '{1, 4'b1111, D,            1, 4'b0000, 0, 8'h00, 0};
        tv[1]  = '{0, 4'b0100, 32'h13A51110, 1, 4'b0100, 0, 8'h00, 0};
        tv[2]  = '{0, 4'b0000, D,            1, 4'b0000, 1, 8'hA5, 2};
        tv[3]  = '{0, 4'b0000, D,            1, 4'b0000, 0, 8'hA5, 2};
        tv[4]  = '{1, 4'b0000, D,            0, 4'b0000, 0, 8'hA5, 2};
        tv[5]  = '{0, 4'b1111, D,            1, 4'b0001, 0, 8'h00, 0};
        tv[6]  = '{0, 4'b1111, D,            1, 4'b0010, 1, 8'h10, 0};
        tv[7]  = '{0, 4'b1111, D,            1, 4'b0100, 1, 8'h11, 1};
        tv[8]  = '{0, 4'b1111, D,            1, 4'b1000, 1, 8'h12, 2};
        tv[9]  = '{0, 4'b1111, D,            1, 4'b0001, 1, 8'h13, 3};
        tv[10] = '{0, 4'b0000, D,            1, 4'b0000, 1, 8'h10, 0};
        tv[11] = '{0, 4'b0000, D,            1, 4'b0000, 0, 8'h10, 0};
        tv[12] = '{0, 4'b0001, D,            1, 4'b0001, 0, 8'h10, 0};
        tv[13] = '{0, 4'b0010, D,            0, 4'b0000, 1, 8'h10, 0};
        tv[14] = '{0, 4'b0010, D,            0, 4'b0000, 1, 8'h10, 0};
        tv[15] = '{0, 4'b0010, D,            0, 4'b0000, 1, 8'h10, 0};
        tv[16] = '{0, 4'b0010, D,            1, 4'b0010, 1, 8'h10, 0};
        tv[17] = '{0, 4'b0000, D,            1, 4'b0000, 1, 8'h11, 1};
        tv[18] = '{0, 4'b0000, D,            0, 4'b0000, 0, 8'h11, 1};
        tv[19] = '{0, 4'b0100, D,            1, 4'b0100, 0, 8'h11, 1};
        tv[20] = '{0, 4'b1001, D,            1, 4'b1000, 1, 8'h12, 2};
        tv[21] = '{0, 4'b0001, D,            1, 4'b0001, 1, 8'h13, 3};
        tv[22] = '{0, 4'b1001, D,            1, 4'b1000, 1, 8'h10, 0};
        tv[23] = '{0, 4'b0000, D,            1, 4'b0000, 1, 8'h13, 3};
        tv[24] = '{0, 4'b0001, 32'h1312117E, 1, 4'b0001, 0, 8'h13, 3};
        tv[25] = '{1, 4'b1111, D,            0, 4'b0000, 1, 8'h7E, 0};
        tv[26] = '{0, 4'b1111, D,            0, 4'b0001, 0, 8'h00, 0};
        tv[27] = '{0, 4'b1110, D,            1, 4'b0010, 1, 8'h10, 0};

        reset    = 1'b1;
        req_val  = '0;
        req_data = D;
        out_rdy  = 1'b0;
        step();

        for (int i = 0; i < 28; i++) begin
            reset    = tv[i].rst;
            req_val  = tv[i].val;
            req_data = tv[i].data;
            out_rdy  = tv[i].ordy;
            #1;
            st = buf_state_t'(out_val);
            chk($sformatf("v%0d req_rdy", i), int'(req_rdy), int'(tv[i].rr));
            chk($sformatf("v%0d out_val", i), int'(st), int'(tv[i].ov));
            chk($sformatf("v%0d out_data", i), int'(out_data), int'(tv[i].od));
            chk($sformatf("v%0d out_id", i), int'(out_id), int'(tv[i].oid));
            step();
        end

        // Back-to-back fills from req 3 with the consumer always ready
        reset    = 1'b0;
        req_val  = 4'b1000;
        req_data = D;
        out_rdy  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("tput%0d req_rdy", k), int'(req_rdy), 8);
            step();
            chk($sformatf("tput%0d out_val", k), int'(out_val), 1);
            chk($sformatf("tput%0d out_data", k), int'(out_data), 8'h13);
            chk($sformatf("tput%0d out_id", k), int'(out_id), 3);
        end

        // Stall while req 0 waits, then release the consumer
        req_val  = 4'b0001;
        req_data = 32'h1312_115C;
        waited   = 0;
        got      = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            out_rdy = (k >= 2);
            #1;
            if (req_rdy[0]) begin
                got = 1'b1;
            end else begin
                chk("stall out_data", int'(out_data), 8'h13);
                chk("stall req_rdy", int'(req_rdy), 0);
                waited++;
                step();
            end
        end
        chk("stall grant seen", int'(got), 1);
        chk("stall cycles", waited, 2);
        step();
        req_val = 4'b0000;
        chk("release out_val", int'(out_val), 1);
        chk("release out_data", int'(out_data), 8'h5C);
        chk("release out_id", int'(out_id), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
